keypad_scanner: RTL

- Upstream stage of the keypad-capture state machine.
- Drives the 4x4 keypad columns one-hot and rotates through them at a fixed dwell rate while scanning is enabled.
- Synchronizes the raw row inputs and blanks stale rows after each column change.
- Produces `row_stable`, `col` and the encoded `pressed_value` bus that the capture FSM consumes.

---
 rtl/keypad_scanner_pkg.sv | 35 +++
 rtl/keypad_scanner_if.sv | 31 +++
 rtl/keypad_scanner_sync_chain.sv | 25 ++
 rtl/keypad_scanner.sv | 114 +++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared constants and helpers for the 4x4 keypad scanner.
// Optional build macro: KEYPAD_MULTIKEY_REJECT_EN (consumed by keypad_scanner).
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // Column drive value after reset: column 0 selected.
  localparam logic [NUM_COLS-1:0] COL_RESET = 4'b0001;

  // Key codes indexed by {row_idx, col_idx}; entry 0 is row 0 / col 0.
  //   r0: 1 2 3 A    r1: 4 5 6 B    r2: 7 8 9 C    r3: E 0 F D
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,   // row 3, cols 3..0
    4'hC, 4'h9, 4'h8, 4'h7,   // row 2
    4'hB, 4'h6, 4'h5, 4'h4,   // row 1
    4'hA, 4'h3, 4'h2, 4'h1    // row 0
  };

  // Index of the lowest set bit; a multi-bit input resolves to the lowest index.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // True when more than one bit of v is set.
  function automatic logic multi_bit(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: host side (master) and scanner side (slave).
interface keypad_scanner_if;

  logic        enable_scan;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  row_stable;
  logic [11:0] pressed_value;
  logic        key_valid;

  // Host / capture side: drives scan control and the raw keypad rows.
  modport master (
    output enable_scan,
    output row,
    input  col,
    input  row_stable,
    input  pressed_value,
    input  key_valid
  );

  // Scanner side.
  modport slave (
    input  enable_scan,
    input  row,
    output col,
    output row_stable,
    output pressed_value,
    output key_valid
  );

endinterface

// File: rtl/keypad_scanner_sync_chain.sv
// Multi-flop synchronizer for asynchronous inputs; clears asynchronously.
module sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // Shift the raw input through STAGES flops; stage 0 samples the pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: one-hot column rotation, row synchronization,
// post-rotation blanking and key encoding for the capture FSM.
// Optional build macro: KEYPAD_MULTIKEY_REJECT_EN -- when defined, a row
// pattern with more than one bit set is treated as no key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV    = 12000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.slave  bus
);

  localparam int CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BLANK_W = $clog2(SYNC_STAGES + 2);

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(SYNC_STAGES + 1);

  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [3:0]         col_q,   col_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic [3:0]         row_stable_q, row_stable_d;
  logic [11:0]        pressed_q,    pressed_d;
  logic               valid_q,      valid_d;

  logic [3:0] sync_row;
  logic [3:0] row_eff;
  logic [1:0] row_idx;
  logic [1:0] col_idx;
  logic       col_change;

  // Row pins are asynchronous to clk; bring them into the clock domain.
  sync_chain #(
    .WIDTH  (NUM_ROWS),
    .STAGES (SYNC_STAGES)
  ) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.row),
    .q_o   (sync_row)
  );

  // Dwell counter and column rotation; both freeze while scanning is disabled.
  assign col_change = bus.enable_scan && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    col_d = col_q;
    if (bus.enable_scan) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        col_d = {col_q[2:0], col_q[3]};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Blank window: reload on every column change, then count down and park at 0.
  always_comb begin
    blank_d = blank_q;
    if (col_change) begin
      blank_d = BLANK_LOAD;
    end else if (blank_q != '0) begin
      blank_d = blank_q - BLANK_W'(1);
    end
  end

  // Encode the synchronized row; outputs only update once the blank window is over.
  always_comb begin
    row_eff = sync_row;
`ifdef KEYPAD_MULTIKEY_REJECT_EN
    if (multi_bit(sync_row)) row_eff = 4'd0;
`endif
    row_idx      = onehot_to_idx(row_eff);
    col_idx      = onehot_to_idx(col_q);
    row_stable_d = 4'd0;
    valid_d      = 1'b0;
    pressed_d    = pressed_q;
    if ((blank_d == '0) && (row_eff != 4'd0)) begin
      row_stable_d = row_eff;
      valid_d      = 1'b1;
      pressed_d    = {4'(4'b0001 << row_idx), col_q, KEY_MAP[{row_idx, col_idx}]};
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      col_q        <= COL_RESET;
      blank_q      <= BLANK_LOAD;
      row_stable_q <= 4'd0;
      pressed_q    <= 12'd0;
      valid_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      blank_q      <= blank_d;
      row_stable_q <= row_stable_d;
      pressed_q    <= pressed_d;
      valid_q      <= valid_d;
    end
  end

  assign bus.col           = col_q;
  assign bus.row_stable    = row_stable_q;
  assign bus.pressed_value = pressed_q;
  assign bus.key_valid     = valid_q;

endmodule
